// File: rtl/hardwired_control_unit.sv
// Hardwired Moore control sequencer for the System datapath: fetch (F0-F2),
// decode (T3), then ALU / in / out / mfhi / mflo / nop / halt execution.
module hardwired_control_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic                  inport_valid,
  output logic                  PCout,
  output logic                  Zhi_out,
  output logic                  Zlo_out,
  output logic                  MDRout,
  output logic                  HIout,
  output logic                  LOout,
  output logic                  Inport_out,
  output logic                  Cout,
  output logic                  MARin,
  output logic                  Zin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  HIin,
  output logic                  LOin,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Grc,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  BAout,
  output logic                  IncPC,
  output logic [4:0]            opcode,
  output logic                  Mem_Read,
  output logic                  Mem_Write,
  output logic                  Mem_enable512x32,
  output logic                  outport_in,
  output logic                  inport_data_ready,
  output logic                  run,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_T3, S_A4, S_A5, S_IN4, S_HALT
  } state_t;

  state_t     state, next_state;
  logic [4:0] ir_op;
  logic       unused_ir;

  assign ir_op     = IR[DATA_WIDTH-1 -: 5];
  assign unused_ir = ^IR[DATA_WIDTH-6:0];

  // Reserved for ld/st/branch extensions.
  assign Zhi_out   = 1'b0;
  assign Cout      = 1'b0;
  assign HIin      = 1'b0;
  assign LOin      = 1'b0;
  assign BAout     = 1'b0;
  assign Mem_Write = 1'b0;

  // NOTE: state and counter use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clock) begin
    if (clear) begin
      state       <= S_RST;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (state == S_F2) instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  // NOTE: every output and next_state gets a default before the case, so no
  // path through this block leaves a value unassigned (no inferred latches).
  always_comb begin
    next_state        = S_RST;
    PCout             = 1'b0;
    Zlo_out           = 1'b0;
    MDRout            = 1'b0;
    HIout             = 1'b0;
    LOout             = 1'b0;
    Inport_out        = 1'b0;
    MARin             = 1'b0;
    Zin               = 1'b0;
    PCin              = 1'b0;
    MDRin             = 1'b0;
    IRin              = 1'b0;
    Yin               = 1'b0;
    Gra               = 1'b0;
    Grb               = 1'b0;
    Grc               = 1'b0;
    Rin               = 1'b0;
    Rout              = 1'b0;
    IncPC             = 1'b0;
    opcode            = 5'b0;
    Mem_Read          = 1'b0;
    Mem_enable512x32  = 1'b0;
    outport_in        = 1'b0;
    inport_data_ready = 1'b0;
    illegal           = 1'b0;
    run               = state inside {S_F0, S_F1, S_F2, S_T3, S_A4, S_A5, S_IN4};

    unique case (state)
      S_RST: next_state = S_F0;
      S_F0: begin
        PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1;
        next_state = S_F1;
      end
      S_F1: begin
        Zlo_out = 1'b1; PCin = 1'b1; MDRin = 1'b1;
        Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        next_state = S_F2;
      end
      S_F2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        next_state = S_F0;
        case (ir_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            next_state = S_A4;
          end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1; end
          OP_MFHI: begin Gra = 1'b1; Rin = 1'b1; HIout = 1'b1; end
          OP_MFLO: begin Gra = 1'b1; Rin = 1'b1; LOout = 1'b1; end
          OP_NOP:  next_state = S_F0;
          OP_HALT: next_state = S_HALT;
          // Hold in decode until the input device offers data.
          OP_IN:   next_state = inport_valid ? S_IN4 : S_T3;
          default: illegal = 1'b1;
        endcase
      end
      S_A4: begin
        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir_op;
        next_state = S_A5;
      end
      S_A5: begin
        Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        next_state = S_F0;
      end
      S_IN4: begin
        Gra = 1'b1; Rin = 1'b1; Inport_out = 1'b1; inport_data_ready = 1'b1;
        next_state = S_F0;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Scoreboard bench: a per-instruction micro-step model pushes the expected
// control word each cycle; a negedge monitor pops and compares.
module tb_hardwired_control_unit;

  localparam int CW = 4;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef struct packed {
    logic PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC;
    logic Mem_Read, Mem_Write, Mem_enable512x32;
    logic outport_in, inport_data_ready, run, illegal;
    logic [4:0]    opcode;
    logic [CW-1:0] cnt;
  } obs_t;

  typedef struct {
    obs_t  e;
    string name;
  } exp_t;

  // vmode: 0 = inport_valid random (must be ignored), 1 = held low, 2 = high
  typedef struct {
    obs_t  e;
    string name;
    int    vmode;
    bit    retire;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear, inport_valid;
  logic [31:0]   IR;
  logic PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC;
  logic Mem_Read, Mem_Write, Mem_enable512x32;
  logic outport_in, inport_data_ready, run, illegal;
  logic [4:0]    opcode;
  logic [CW-1:0] instr_count;

  hardwired_control_unit #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .Clock(clk), .clear(clear), .IR(IR), .inport_valid(inport_valid),
    .PCout(PCout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Inport_out(Inport_out), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .IncPC(IncPC), .opcode(opcode),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_enable512x32(Mem_enable512x32),
    .outport_in(outport_in), .inport_data_ready(inport_data_ready),
    .run(run), .illegal(illegal), .instr_count(instr_count)
  );

  obs_t act;
  assign act = {PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout,
                MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
                Gra, Grb, Grc, Rin, Rout, BAout, IncPC,
                Mem_Read, Mem_Write, Mem_enable512x32,
                outport_in, inport_data_ready, run, illegal,
                opcode, instr_count};

  exp_t          exp_q[$];
  step_t         prog[$];
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] cnt_model = '0;

  task automatic check(input string name, input obs_t a, input obs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, a, e);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      check(x.name, act, x.e);
    end
  end

  // One clock cycle: record what the DUT must show now, set the inputs
  // sampled at the closing edge, then advance.
  task automatic drive(input obs_t e, input string name, input logic clr,
                       input logic v);
    exp_t x;
    x.e     = e;
    x.e.cnt = cnt_model;
    x.name  = name;
    exp_q.push_back(x);
    clear        = clr;
    inport_valid = v;
    @(posedge clk);
    #1;
    if (clr) cnt_model = '0;
  endtask

  // `hold` cycles in RST with clear high, then one with clear low.
  task automatic reset_tail(input int hold);
    repeat (hold) drive('0, "rst_hold", 1'b1, 1'($urandom_range(0, 1)));
    drive('0, "rst_release", 1'b0, 1'($urandom_range(0, 1)));
  endtask

  function automatic step_t mk(input string name, input int vmode = 0,
                               input bit retire = 1'b0);
    step_t s;
    s.e      = '0;
    s.e.run  = 1'b1;
    s.name   = name;
    s.vmode  = vmode;
    s.retire = retire;
    return s;
  endfunction

  // Reference: the list of control words an instruction walks through.
  task automatic build(input logic [31:0] ir, input int wait_n, input int halt_n);
    step_t s;
    logic [4:0] op;
    op = ir[31:27];
    prog.delete();
    s = mk("F0"); s.e.PCout = 1; s.e.IncPC = 1; s.e.MARin = 1; s.e.Zin = 1;
    prog.push_back(s);
    s = mk("F1"); s.e.Zlo_out = 1; s.e.PCin = 1; s.e.MDRin = 1;
    s.e.Mem_Read = 1; s.e.Mem_enable512x32 = 1;
    prog.push_back(s);
    s = mk("F2", 0, 1'b1); s.e.MDRout = 1; s.e.IRin = 1;
    prog.push_back(s);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        s = mk("T3_alu"); s.e.Grb = 1; s.e.Rout = 1; s.e.Yin = 1; prog.push_back(s);
        s = mk("A4"); s.e.Grc = 1; s.e.Rout = 1; s.e.Zin = 1; s.e.opcode = op;
        prog.push_back(s);
        s = mk("A5"); s.e.Zlo_out = 1; s.e.Gra = 1; s.e.Rin = 1; prog.push_back(s);
      end
      OP_OUT: begin
        s = mk("T3_out"); s.e.Gra = 1; s.e.Rout = 1; s.e.outport_in = 1;
        prog.push_back(s);
      end
      OP_MFHI: begin
        s = mk("T3_mfhi"); s.e.Gra = 1; s.e.Rin = 1; s.e.HIout = 1; prog.push_back(s);
      end
      OP_MFLO: begin
        s = mk("T3_mflo"); s.e.Gra = 1; s.e.Rin = 1; s.e.LOout = 1; prog.push_back(s);
      end
      OP_NOP: prog.push_back(mk("T3_nop"));
      OP_HALT: begin
        prog.push_back(mk("T3_halt"));
        for (int i = 0; i < halt_n; i++) begin
          s = mk("HALT"); s.e.run = 0; prog.push_back(s);
        end
      end
      OP_IN: begin
        for (int i = 0; i < wait_n; i++) prog.push_back(mk("T3_in_wait", 1));
        prog.push_back(mk("T3_in", 2));
        s = mk("IN4"); s.e.Gra = 1; s.e.Rin = 1; s.e.Inport_out = 1;
        s.e.inport_data_ready = 1;
        prog.push_back(s);
      end
      default: begin
        s = mk("T3_illegal"); s.e.illegal = 1; prog.push_back(s);
      end
    endcase
  endtask

  // abort_at: step index at which clear is raised (-1 = run to completion).
  // A halt with no abort is always released on its last HALT cycle.
  task automatic do_instr(input logic [31:0] ir, input int wait_n,
                          input int halt_n, input int abort_at);
    int   ab;
    logic v;
    IR = ir;
    build(ir, wait_n, halt_n);
    ab = abort_at;
    if (prog[prog.size()-1].name == "HALT" && ab < 0) ab = prog.size() - 1;
    for (int i = 0; i < prog.size(); i++) begin
      case (prog[i].vmode)
        1:       v = 1'b0;
        2:       v = 1'b1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (i == ab) begin
        drive(prog[i].e, prog[i].name, 1'b1, v);
        reset_tail(0);
        return;
      end
      drive(prog[i].e, prog[i].name, 1'b0, v);
      if (prog[i].retire) cnt_model = cnt_model + 1'b1;
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = op;
    return r;
  endfunction

  initial begin
    logic [4:0] legal [10];
    logic [4:0] op;
    int         abort_at;
    legal = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_IN, OP_OUT,
              OP_MFHI, OP_MFLO, OP_NOP, OP_HALT};

    clear = 1'b1; inport_valid = 1'b0; IR = $urandom;
    repeat (2) @(posedge clk);
    #1;
    reset_tail(2);

    do_instr(32'h1800_0000, 0, 0, -1);          // add
    do_instr(32'hB180_0000, 3, 0, -1);          // in, three wait cycles
    do_instr(32'hB980_0000, 0, 0, -1);          // out
    do_instr(32'hD800_0000, 0, 20, -1);         // halt for 20 cycles, then clear
    do_instr(mk_ir(5'b11111), 0, 0, -1);        // illegal
    do_instr(mk_ir(OP_MFHI), 0, 0, -1);
    do_instr(mk_ir(OP_MFLO), 0, 0, -1);

    do_instr(mk_ir(OP_NOP), 0, 0, 0);           // clear during F0
    repeat (16) do_instr(mk_ir(OP_NOP), 0, 0, -1);
    do_instr(mk_ir(OP_SUB), 0, 0, 4);           // clear in A4
    do_instr(mk_ir(OP_IN), 1, 0, 5);            // clear in IN4: no repeated ack
    do_instr(mk_ir(OP_IN), 0, 0, -1);           // valid already high in T3
    do_instr(mk_ir(OP_AND), 0, 0, -1);
    do_instr(mk_ir(OP_OR), 0, 0, -1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 10) == 0) begin
        do op = 5'($urandom_range(0, 31)); while (op inside {legal});
      end else begin
        op = legal[$urandom_range(0, 9)];
      end
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      do_instr(mk_ir(op), $urandom_range(0, 4), $urandom_range(1, 5), abort_at);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
